// File: rtl/bist_pkg.sv
// Shared types and constants for the 8-bit BIST datapath.
package bist_pkg;

  localparam int unsigned PCNT_W = 16;
  localparam int unsigned LAT_W  = 4;

  // Defaults shared with the LFSR and MISR blocks.
  localparam logic [7:0] DEFAULT_SEED   = 8'h01;
  localparam logic [7:0] DEFAULT_GOLDEN = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH,
    S_CAPTURE,
    S_DONE
  } bist_state_t;

endpackage

// File: rtl/bist_pattern_counter.sv
// Pattern counter: 16-bit up-counter with synchronous clear and enable,
// flagging the final pattern (count == N_PATTERNS-1).
module bist_pattern_counter
  import bist_pkg::*;
#(
  parameter int unsigned N_PATTERNS = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [PCNT_W-1:0] count,
  output logic              last
);

  // Count applied patterns; clear has priority over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + PCNT_W'(1);
  end

  assign last = (count == PCNT_W'(N_PATTERNS - 1));

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: seeds the LFSR, clears the MISR, runs N_PATTERNS patterns,
// flushes the CUT pipeline, then captures and checks the MISR signature.
module bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       N_PATTERNS  = 255,
  parameter int unsigned       CUT_LATENCY = 0,
  parameter logic [WIDTH-1:0]  GOLDEN      = DEFAULT_GOLDEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  misr_sig,
  output logic              lfsr_load,
  output logic              lfsr_en,
  output logic              misr_clr,
  output logic              misr_en,
  output logic              test_mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [WIDTH-1:0]  signature,
  output logic [15:0]       pattern_cnt
);

  bist_state_t        state, state_next;
  logic [LAT_W-1:0]   lat_cnt;
  logic               last_pattern;
  logic               clr_result;

  // Results are wiped whenever a run starts or the block returns to IDLE,
  // so pass/signature/pattern_cnt read 0 during INIT and after an abort.
  assign clr_result = (state_next == S_IDLE) || (state_next == S_INIT);

  bist_pattern_counter #(
    .N_PATTERNS(N_PATTERNS)
  ) u_pcnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_result),
    .en    (state == S_RUN),
    .count (pattern_cnt),
    .last  (last_pattern)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (start) state_next = S_INIT;
      S_INIT:    state_next = S_RUN;
      S_RUN:     if (last_pattern)
                   state_next = (CUT_LATENCY > 0) ? S_FLUSH : S_CAPTURE;
      S_FLUSH:   if (lat_cnt == LAT_W'(1)) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_DONE;
      S_DONE:    if (start) state_next = S_INIT;
      default:   state_next = S_IDLE;
    endcase
    if (abort)
      state_next = S_IDLE;
  end

  // Output decode from the state register only.
  always_comb begin
    lfsr_load = 1'b0;
    misr_clr  = 1'b0;
    lfsr_en   = 1'b0;
    misr_en   = 1'b0;
    test_mode = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_INIT:    begin lfsr_load = 1'b1; misr_clr = 1'b1; test_mode = 1'b1; busy = 1'b1; end
      S_RUN:     begin lfsr_en = 1'b1; misr_en = 1'b1; test_mode = 1'b1; busy = 1'b1; end
      S_FLUSH:   begin misr_en = 1'b1; test_mode = 1'b1; busy = 1'b1; end
      S_CAPTURE: begin test_mode = 1'b1; busy = 1'b1; end
      S_DONE:    done = 1'b1;
      default:   ;
    endcase
  end

  // CUT flush down-counter, loaded on the last RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lat_cnt <= '0;
    else if (state_next == S_IDLE)
      lat_cnt <= '0;
    else if (state == S_RUN && last_pattern)
      lat_cnt <= LAT_W'(CUT_LATENCY);
    else if (state == S_FLUSH)
      lat_cnt <= lat_cnt - LAT_W'(1);
  end

  // Signature capture and golden comparison at the end of CAPTURE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature <= '0;
      pass      <= 1'b0;
    end else if (clr_result) begin
      signature <= '0;
      pass      <= 1'b0;
    end else if (state == S_CAPTURE) begin
      signature <= misr_sig;
      pass      <= (misr_sig == GOLDEN);
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: one instance with CUT_LATENCY=0 and
// one with CUT_LATENCY=2, both N_PATTERNS=4.
module tb_bist_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: N=4, L=0, golden A5
  logic       rst, start, abort;
  logic [7:0] misr_sig;
  logic       lfsr_load, lfsr_en, misr_clr, misr_en, test_mode, busy, done, pass;
  logic [7:0] signature;
  logic [15:0] pattern_cnt;

  // Instance B: N=4, L=2, golden 5A
  logic       rst_l, start_l, abort_l;
  logic [7:0] misr_sig_l;
  logic       lfsr_load_l, lfsr_en_l, misr_clr_l, misr_en_l, test_mode_l, busy_l, done_l, pass_l;
  logic [7:0] signature_l;
  logic [15:0] pattern_cnt_l;

  bist_controller #(
    .WIDTH(8), .N_PATTERNS(4), .CUT_LATENCY(0), .GOLDEN(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .misr_sig(misr_sig),
    .lfsr_load(lfsr_load), .lfsr_en(lfsr_en), .misr_clr(misr_clr), .misr_en(misr_en),
    .test_mode(test_mode), .busy(busy), .done(done), .pass(pass),
    .signature(signature), .pattern_cnt(pattern_cnt)
  );

  bist_controller #(
    .WIDTH(8), .N_PATTERNS(4), .CUT_LATENCY(2), .GOLDEN(8'h5A)
  ) dut_lat (
    .clk(clk), .rst(rst_l), .start(start_l), .abort(abort_l), .misr_sig(misr_sig_l),
    .lfsr_load(lfsr_load_l), .lfsr_en(lfsr_en_l), .misr_clr(misr_clr_l), .misr_en(misr_en_l),
    .test_mode(test_mode_l), .busy(busy_l), .done(done_l), .pass(pass_l),
    .signature(signature_l), .pattern_cnt(pattern_cnt_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_a(input string t);
    check({t, " lfsr_load"},   32'(lfsr_load),   32'd0);
    check({t, " misr_clr"},    32'(misr_clr),    32'd0);
    check({t, " lfsr_en"},     32'(lfsr_en),     32'd0);
    check({t, " misr_en"},     32'(misr_en),     32'd0);
    check({t, " test_mode"},   32'(test_mode),   32'd0);
    check({t, " busy"},        32'(busy),        32'd0);
    check({t, " done"},        32'(done),        32'd0);
    check({t, " pass"},        32'(pass),        32'd0);
    check({t, " signature"},   32'(signature),   32'd0);
    check({t, " pattern_cnt"}, 32'(pattern_cnt), 32'd0);
  endtask

  task automatic check_idle_b(input string t);
    check({t, " lfsr_load"},   32'(lfsr_load_l),   32'd0);
    check({t, " misr_clr"},    32'(misr_clr_l),    32'd0);
    check({t, " lfsr_en"},     32'(lfsr_en_l),     32'd0);
    check({t, " misr_en"},     32'(misr_en_l),     32'd0);
    check({t, " test_mode"},   32'(test_mode_l),   32'd0);
    check({t, " busy"},        32'(busy_l),        32'd0);
    check({t, " done"},        32'(done_l),        32'd0);
    check({t, " pass"},        32'(pass_l),        32'd0);
    check({t, " signature"},   32'(signature_l),   32'd0);
    check({t, " pattern_cnt"}, 32'(pattern_cnt_l), 32'd0);
  endtask

  // Full run on instance A: INIT c1, RUN c2-5, CAPTURE c6, DONE c7.
  // poke: cycle in which start is re-asserted (0 = never).
  task automatic run_a(input string t, input logic [7:0] sig, input logic ok,
                       input int unsigned poke);
    logic [15:0] cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int unsigned c = 1; c <= 7; c++) begin
      cnt = (c <= 1) ? 16'd0 : (c <= 5) ? 16'(c - 2) : 16'd4;
      check($sformatf("%s c%0d lfsr_load", t, c), 32'(lfsr_load), 32'(c == 1));
      check($sformatf("%s c%0d misr_clr", t, c),  32'(misr_clr),  32'(c == 1));
      check($sformatf("%s c%0d lfsr_en", t, c),   32'(lfsr_en),   32'(c >= 2 && c <= 5));
      check($sformatf("%s c%0d misr_en", t, c),   32'(misr_en),   32'(c >= 2 && c <= 5));
      check($sformatf("%s c%0d test_mode", t, c), 32'(test_mode), 32'(c <= 6));
      check($sformatf("%s c%0d busy", t, c),      32'(busy),      32'(c <= 6));
      check($sformatf("%s c%0d done", t, c),      32'(done),      32'(c == 7));
      check($sformatf("%s c%0d pattern_cnt", t, c), 32'(pattern_cnt), 32'(cnt));
      if (c == 1) begin
        check($sformatf("%s c1 pass", t),      32'(pass),      32'd0);
        check($sformatf("%s c1 signature", t), 32'(signature), 32'd0);
      end
      if (c == 7) begin
        check($sformatf("%s c7 pass", t),      32'(pass),      32'(ok));
        check($sformatf("%s c7 signature", t), 32'(signature), 32'(sig));
      end
      if (c < 7) begin
        if (c == poke) start = 1'b1;
        step();
        start = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; misr_sig = 8'hA5;
    rst_l = 1'b1; start_l = 1'b0; abort_l = 1'b0; misr_sig_l = 8'h5A;
    #12;
    check_idle_a("reset A");
    check_idle_b("reset B");
    rst = 1'b0; rst_l = 1'b0;
    step();
    check_idle_a("idle A");

    // Matching signature
    run_a("t1", 8'hA5, 1'b1, 0);

    // Mismatching signature, started from DONE
    misr_sig = 8'h3C;
    run_a("t2", 8'h3C, 1'b0, 0);

    // Latency instance: INIT c1, RUN c2-5, FLUSH c6-7, CAPTURE c8, DONE c9
    start_l = 1'b1;
    step();
    start_l = 1'b0;
    for (int unsigned c = 1; c <= 9; c++) begin
      check($sformatf("t3 c%0d lfsr_en", c),   32'(lfsr_en_l),   32'(c >= 2 && c <= 5));
      check($sformatf("t3 c%0d misr_en", c),   32'(misr_en_l),   32'(c >= 2 && c <= 7));
      check($sformatf("t3 c%0d test_mode", c), 32'(test_mode_l), 32'(c <= 8));
      check($sformatf("t3 c%0d done", c),      32'(done_l),      32'(c == 9));
      if (c < 9) step();
    end
    check("t3 pass",        32'(pass_l),        32'd1);
    check("t3 signature",   32'(signature_l),   32'h5A);
    check("t3 pattern_cnt", 32'(pattern_cnt_l), 32'd4);

    // Abort in RUN cycle 3 with start also high
    misr_sig = 8'hA5;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("t4 c3 busy", 32'(busy), 32'd1);
    check("t4 c3 pattern_cnt", 32'(pattern_cnt), 32'd1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_idle_a("t4 abort");
    step();
    step();
    check_idle_a("t4 idle");
    run_a("t4 rerun", 8'hA5, 1'b1, 0);

    // start pulsed in RUN cycle 3 is ignored
    run_a("t5", 8'hA5, 1'b1, 3);

    // Asynchronous reset in FLUSH on the latency instance
    start_l = 1'b1;
    step();
    start_l = 1'b0;
    for (int unsigned c = 2; c <= 6; c++) step();
    check("t6 flush misr_en", 32'(misr_en_l), 32'd1);
    check("t6 flush lfsr_en", 32'(lfsr_en_l), 32'd0);
    check("t6 flush pattern_cnt", 32'(pattern_cnt_l), 32'd4);
    #2 rst_l = 1'b1;
    #1;
    check_idle_b("t6 async rst");
    step();
    #2 rst_l = 1'b0;
    step();
    step();
    step();
    check_idle_b("t6 after release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
